// File: rtl/inst_issue_unit.sv
// inst_issue_unit: front end of the Tomasulo core.
// Fetches instruction words into a small in-order queue and issues at most
// one instruction per cycle onto the CDB_inst lane (fu, inst, RB index).
// A free FU is chosen from the class that matches the head opcode. RB
// entries are allocated round-robin.
// Optional build macro: ISSUE_STALL_CNT_EN adds the stall_fu_cnt and
// stall_rb_cnt saturating stall counters.
module inst_issue_unit #(
    parameter int          WORD_SIZE    = 32,
    parameter int          OPCODE_WIDTH = 6,
    parameter int          FU_NUM       = 10,
    parameter int          STORER_NUM   = 2,
    parameter int          FU_INDEX     = 4,
    parameter int          RB_SIZE      = 16,
    parameter int          RB_INDEX     = 4,
    parameter int          IQ_DEPTH     = 4,
    parameter logic [5:0]  INST_SW      = 6'h2B,
    parameter logic [5:0]  INST_HALT    = 6'h3F
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_en,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic [WORD_SIZE-1:0] imem_data,
    input  logic                 imem_valid,
    input  logic [FU_NUM-1:0]    busy,
    input  logic                 rb_commit,
    input  logic                 flush,
    input  logic [WORD_SIZE-1:0] flush_pc,
    output logic [FU_INDEX-1:0]  CDB_inst_fu,
    output logic [WORD_SIZE-1:0] CDB_inst_inst,
    output logic [RB_INDEX-1:0]  CDB_inst_RBindex,
    output logic                 halted
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [15:0]          stall_fu_cnt,
    output logic [15:0]          stall_rb_cnt
`endif
);

    localparam int IQ_AW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int IQ_CW = IQ_AW + 1;
    localparam int RB_CW = RB_INDEX + 1;
    localparam int ALU_NUM = FU_NUM - STORER_NUM;
    localparam logic [FU_INDEX-1:0] FU_NULL = {FU_INDEX{1'b1}};

    // Architectural state
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] iq_mem_q [IQ_DEPTH];
    logic [IQ_AW-1:0]     iq_rd_q, iq_rd_d;
    logic [IQ_AW-1:0]     iq_wr_q, iq_wr_d;
    logic [IQ_CW-1:0]     iq_cnt_q, iq_cnt_d;
    logic [RB_INDEX-1:0]  rb_tail_q, rb_tail_d;
    logic [RB_CW-1:0]     rb_cnt_q, rb_cnt_d;
    logic                 halted_q, halted_d;
    logic [FU_NUM-1:0]    pending_q, pending_d;
    logic [FU_INDEX-1:0]  fu_q, fu_d;
    logic [WORD_SIZE-1:0] inst_q, inst_d;
    logic [RB_INDEX-1:0]  rbidx_q, rbidx_d;

    // Decode / decision signals
    logic                    iq_empty, iq_full;
    logic [WORD_SIZE-1:0]    head;
    logic [OPCODE_WIDTH-1:0] head_op;
    logic                    head_is_sw, head_is_halt;
    logic                    head_ok;
    logic [FU_NUM-1:0]       class_mask;
    logic [FU_NUM-1:0]       avail;
    logic                    cand_found;
    logic [FU_INDEX-1:0]     cand_idx;
    logic [FU_NUM-1:0]       cand_onehot;
    logic                    rb_full;
    logic                    do_issue, do_push, do_commit;

    // Queue head decode, candidate FU selection and the per-cycle decisions
    always_comb begin
        iq_empty     = (iq_cnt_q == '0);
        iq_full      = (iq_cnt_q == IQ_CW'(IQ_DEPTH));
        head         = iq_mem_q[iq_rd_q];
        head_op      = head[WORD_SIZE-1 -: OPCODE_WIDTH];
        head_is_sw   = (head_op == INST_SW);
        head_is_halt = (head_op == INST_HALT);
        head_ok      = !iq_empty && !head_is_halt && !halted_q;

        class_mask = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            class_mask[i] = head_is_sw ? (i >= ALU_NUM) : (i < ALU_NUM);
        end
        // pending masks the FU granted last cycle until its busy bit rises
        avail = class_mask & ~busy & ~pending_q;

        cand_found  = 1'b0;
        cand_idx    = FU_NULL;
        cand_onehot = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            if (avail[i] && !cand_found) begin
                cand_found     = 1'b1;
                cand_idx       = FU_INDEX'(i);
                cand_onehot[i] = 1'b1;
            end
        end

        rb_full   = (rb_cnt_q == RB_CW'(RB_SIZE));
        do_issue  = head_ok && cand_found && !rb_full && !flush;
        do_push   = fetch_en && imem_valid && !iq_full && !halted_q && !flush;
        do_commit = rb_commit && (rb_cnt_q != '0) && !flush;
    end

    // Next-state computation; flush overrides everything happening this cycle
    always_comb begin
        pc_d      = pc_q;
        iq_rd_d   = iq_rd_q;
        iq_wr_d   = iq_wr_q;
        iq_cnt_d  = iq_cnt_q;
        rb_tail_d = rb_tail_q;
        rb_cnt_d  = rb_cnt_q;
        halted_d  = halted_q;
        pending_d = '0;
        fu_d      = FU_NULL;
        inst_d    = inst_q;
        rbidx_d   = rbidx_q;

        if (flush) begin
            pc_d      = flush_pc;
            iq_rd_d   = '0;
            iq_wr_d   = '0;
            iq_cnt_d  = '0;
            rb_tail_d = '0;
            rb_cnt_d  = '0;
            halted_d  = 1'b0;
        end else begin
            if (do_push) begin
                pc_d    = pc_q + WORD_SIZE'(1);
                iq_wr_d = iq_wr_q + IQ_AW'(1);
            end
            if (do_issue) begin
                iq_rd_d   = iq_rd_q + IQ_AW'(1);
                pending_d = cand_onehot;
                fu_d      = cand_idx;
                inst_d    = head;
                rbidx_d   = rb_tail_q;
                rb_tail_d = (rb_tail_q == RB_INDEX'(RB_SIZE - 1)) ? '0
                                                                  : rb_tail_q + RB_INDEX'(1);
            end
            case ({do_push, do_issue})
                2'b10:   iq_cnt_d = iq_cnt_q + IQ_CW'(1);
                2'b01:   iq_cnt_d = iq_cnt_q - IQ_CW'(1);
                default: iq_cnt_d = iq_cnt_q;
            endcase
            case ({do_issue, do_commit})
                2'b10:   rb_cnt_d = rb_cnt_q + RB_CW'(1);
                2'b01:   rb_cnt_d = rb_cnt_q - RB_CW'(1);
                default: rb_cnt_d = rb_cnt_q;
            endcase
            if (!iq_empty && head_is_halt) begin
                halted_d = 1'b1;
            end
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= '0;
            iq_rd_q   <= '0;
            iq_wr_q   <= '0;
            iq_cnt_q  <= '0;
            rb_tail_q <= '0;
            rb_cnt_q  <= '0;
            halted_q  <= 1'b0;
            pending_q <= '0;
            fu_q      <= FU_NULL;
            inst_q    <= '0;
            rbidx_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            iq_rd_q   <= iq_rd_d;
            iq_wr_q   <= iq_wr_d;
            iq_cnt_q  <= iq_cnt_d;
            rb_tail_q <= rb_tail_d;
            rb_cnt_q  <= rb_cnt_d;
            halted_q  <= halted_d;
            pending_q <= pending_d;
            fu_q      <= fu_d;
            inst_q    <= inst_d;
            rbidx_q   <= rbidx_d;
        end
    end

    // Queue storage; occupancy is tracked by the counters so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            iq_mem_q[iq_wr_q] <= imem_data;
        end
    end

`ifdef ISSUE_STALL_CNT_EN
    logic [15:0] stall_fu_q, stall_fu_d;
    logic [15:0] stall_rb_q, stall_rb_d;

    // Saturating stall counters, cleared by flush
    always_comb begin
        stall_fu_d = stall_fu_q;
        stall_rb_d = stall_rb_q;
        if (flush) begin
            stall_fu_d = '0;
            stall_rb_d = '0;
        end else begin
            if (head_ok && !cand_found && (stall_fu_q != 16'hFFFF)) begin
                stall_fu_d = stall_fu_q + 16'd1;
            end
            if (head_ok && cand_found && rb_full && (stall_rb_q != 16'hFFFF)) begin
                stall_rb_d = stall_rb_q + 16'd1;
            end
        end
    end

    // Stall counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_fu_q <= '0;
            stall_rb_q <= '0;
        end else begin
            stall_fu_q <= stall_fu_d;
            stall_rb_q <= stall_rb_d;
        end
    end

    assign stall_fu_cnt = stall_fu_q;
    assign stall_rb_cnt = stall_rb_q;
`endif

    assign imem_addr        = pc_q;
    assign CDB_inst_fu      = fu_q;
    assign CDB_inst_inst    = inst_q;
    assign CDB_inst_RBindex = rbidx_q;
    assign halted           = halted_q;

endmodule
